// File: rtl/tmc_spi_slave.sv
// tmc_spi_slave: SPI responder for the 40-bit TMC register protocol.
//
// Frames are {wr, addr[6:0], data[31:0]}, MSB first, SPI mode 3. Each frame
// returns {status_in, rd_latch}, where rd_latch holds the data from the
// previous committed access (pipelined read). Writes land in a small
// register file that is also visible through a registered local read port.
//
// Build option: define TMC_SLV_LEN_CHECK_EN to discard frames whose bit
// count is not exactly 40 (frame_err pulses). When undefined, every CS rise
// commits the last 40 bits received and frame_err is tied low.
//
// Ports:
//   clk, rst           system clock, async active-high reset
//   SPI_CS, SPI_CLK    chip select (active-low) and SPI clock, async to clk
//   MOSI / MISO        serial data in / out, MSB first
//   MISO_OE            high while a frame is being shifted
//   status_in          status byte returned in bits 39:32, captured at CS fall
//   reg_rd_addr/data   local read port, one clk latency, 0 when out of range
//   wr_pulse           one-cycle strobe on a committed in-range write
//   wr_addr/wr_data    address/data of the last committed write
//   frame_done         one-cycle strobe on every committed frame
//   frame_err          one-cycle strobe on a discarded frame
module tmc_spi_slave #(
  parameter int unsigned REG_NUM = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SPI_CS,
  input  logic        SPI_CLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE,
  input  logic [7:0]  status_in,
  input  logic [6:0]  reg_rd_addr,
  output logic [31:0] reg_rd_data,
  output logic        wr_pulse,
  output logic [6:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int unsigned AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  // Synchronizers plus edge-detect stage
  logic       cs_s1, cs_s2, cs_d;
  logic       sclk_s1, sclk_s2, sclk_d;
  logic       mosi_s1, mosi_s2, mosi_d;
  logic [1:0] warm;
  logic       cs_arm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      sclk_s1 <= 1'b1;
      sclk_s2 <= 1'b1;
      sclk_d  <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      mosi_d  <= 1'b0;
      warm    <= 2'b00;
      cs_arm  <= 1'b0;
    end else begin
      cs_s1   <= SPI_CS;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sclk_s1 <= SPI_CLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
      mosi_d  <= mosi_s2;
      warm    <= {warm[0], 1'b1};
      // The synchronizer resets to "CS high", so only trust cs_s2 once real
      // pin samples have flushed the reset value; a CS held low across reset
      // then stays ignored until it is seen high.
      if (warm[1] && cs_s2) cs_arm <= 1'b1;
    end
  end

  logic cs_fall, cs_rise, sclk_rise;
  assign cs_fall   = cs_d & ~cs_s2;
  assign cs_rise   = ~cs_d & cs_s2;
  assign sclk_rise = ~sclk_d & sclk_s2;

  state_e      state;
  logic [39:0] tx_sr, rx_sr;
  logic [5:0]  bit_cnt;
  logic [31:0] rd_latch;
  logic [31:0] regs [REG_NUM];

  logic        rx_wr;
  logic [6:0]  rx_addr;
  logic [31:0] rx_data;
  logic        addr_ok;
  logic        frame_ok;

  assign rx_wr   = rx_sr[39];
  assign rx_addr = rx_sr[38:32];
  assign rx_data = rx_sr[31:0];
  assign addr_ok = ({25'd0, rx_addr} < REG_NUM);

`ifdef TMC_SLV_LEN_CHECK_EN
  assign frame_ok = (bit_cnt == 6'd40);
`else
  assign frame_ok = 1'b1;
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      rd_latch   <= '0;
      wr_pulse   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
`ifdef TMC_SLV_LEN_CHECK_EN
      frame_err  <= 1'b0;
`endif
      for (int unsigned i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      wr_pulse   <= 1'b0;
      frame_done <= 1'b0;
`ifdef TMC_SLV_LEN_CHECK_EN
      frame_err  <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (cs_fall && cs_arm) begin
            tx_sr   <= {status_in, rd_latch};
            bit_cnt <= '0;
            state   <= StShift;
          end
        end
        StShift: begin
          if (sclk_rise) begin
            rx_sr <= {rx_sr[38:0], mosi_d};
            tx_sr <= {tx_sr[38:0], 1'b0};
            if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
          end
          if (cs_rise) state <= StCommit;
        end
        StCommit: begin
          if (frame_ok) begin
            if (rx_wr && addr_ok) begin
              regs[rx_addr[AW-1:0]] <= rx_data;
              wr_pulse <= 1'b1;
              wr_addr  <= rx_addr;
              wr_data  <= rx_data;
            end
            // A write echoes its own data on the next frame, dropped or not
            if (rx_wr)        rd_latch <= rx_data;
            else if (addr_ok) rd_latch <= regs[rx_addr[AW-1:0]];
            else              rd_latch <= '0;
            frame_done <= 1'b1;
          end
`ifdef TMC_SLV_LEN_CHECK_EN
          else begin
            frame_err <= 1'b1;
          end
`endif
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_rd_data <= '0;
    end else if ({25'd0, reg_rd_addr} < REG_NUM) begin
      reg_rd_data <= regs[reg_rd_addr[AW-1:0]];
    end else begin
      reg_rd_data <= '0;
    end
  end

  assign MISO    = (state == StShift) & tx_sr[39];
  assign MISO_OE = (state == StShift);

endmodule
